// File: rtl/pull_down_scan_ctrl.sv
// Round-robin emulated pull-down scanner: discharge, settle, sample and debounce each pin bank.
// Optional build macro PD_SCAN_SYNC_EN adds a 2-flop pin synchronizer and 2 extra settle cycles.
module pull_down_scan_ctrl #(
  parameter int BANKS     = 3,
  parameter int WIDTH     = 8,
  parameter int DISCHARGE = 2,
  parameter int SETTLE    = 4,
  parameter int STABLE    = 3,
  localparam int SEL_W    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  inout  wire  [BANKS*WIDTH-1:0] pins,
  output logic [BANKS*WIDTH-1:0] state,
  output logic [BANKS-1:0]       changed,
  output logic                   scan_done,
  output logic [SEL_W-1:0]       bank_sel
);

`ifdef PD_SCAN_SYNC_EN
  localparam int SETTLE_EFF = SETTLE + 2;
`else
  localparam int SETTLE_EFF = SETTLE;
`endif
  localparam int PH_MAX = (DISCHARGE > SETTLE_EFF) ? DISCHARGE : SETTLE_EFF;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = $clog2(STABLE + 1);

  localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(BANKS - 1);
  localparam logic [PH_W-1:0]  DIS_LAST  = PH_W'(DISCHARGE - 1);
  localparam logic [PH_W-1:0]  SET_LAST  = PH_W'(SETTLE_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE);

  typedef enum logic [1:0] {S_IDLE, S_DISCH, S_SETTLE, S_SAMPLE} fsm_t;

  fsm_t             r_fsm, w_fsm_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [SEL_W-1:0] r_bank, w_bank_nxt;
  logic             w_oe, w_sample, w_pass_end;

  logic [BANKS*WIDTH-1:0] w_pins_src;
  logic [WIDTH-1:0]       w_sample_val, w_cand_sel, w_state_sel;
  logic [CNT_W-1:0]       w_cnt_sel, w_cnt_upd;
  logic                   w_accept;

  logic [WIDTH-1:0] r_cand [BANKS];
  logic [CNT_W-1:0] r_cnt  [BANKS];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : CNT_W'(v + 1'b1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_phase <= '0;
      r_bank  <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_phase <= w_phase_nxt;
      r_bank  <= w_bank_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_phase_nxt = r_phase;
    w_bank_nxt  = r_bank;
    unique case (r_fsm)
      S_IDLE: begin
        if (enable) begin
          w_fsm_nxt   = S_DISCH;
          w_phase_nxt = '0;
          w_bank_nxt  = '0;
        end
      end
      S_DISCH: begin
        if (r_phase == DIS_LAST) begin
          w_fsm_nxt   = S_SETTLE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = PH_W'(r_phase + 1'b1);
        end
      end
      S_SETTLE: begin
        if (r_phase == SET_LAST) begin
          w_fsm_nxt   = S_SAMPLE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = PH_W'(r_phase + 1'b1);
        end
      end
      S_SAMPLE: begin
        w_phase_nxt = '0;
        if (r_bank < LAST_BANK) begin
          w_fsm_nxt  = S_DISCH;
          w_bank_nxt = SEL_W'(r_bank + 1'b1);
        end else begin
          // enable is only looked at here and in IDLE, so a pass always completes
          w_fsm_nxt  = enable ? S_DISCH : S_IDLE;
          w_bank_nxt = '0;
        end
      end
      default: begin
        w_fsm_nxt   = S_IDLE;
        w_phase_nxt = '0;
        w_bank_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_oe       = (r_fsm == S_DISCH);
    w_sample   = (r_fsm == S_SAMPLE);
    w_pass_end = w_sample && (r_bank == LAST_BANK);
  end

  // Drive enables come straight from the FSM flops, so async reset floats every pin at once
  for (genvar b = 0; b < BANKS; b++) begin : g_pin
    assign pins[b*WIDTH +: WIDTH] = (w_oe && (r_bank == SEL_W'(b))) ? '0 : 'z;
  end

`ifdef PD_SCAN_SYNC_EN
  logic [BANKS*WIDTH-1:0] r_sync_p0, r_sync_p1;

  always_ff @(posedge clk) begin
    r_sync_p0 <= pins;
    r_sync_p1 <= r_sync_p0;
  end

  assign w_pins_src = r_sync_p1;
`else
  assign w_pins_src = pins;
`endif

  always_comb begin
    w_sample_val = w_pins_src[r_bank*WIDTH +: WIDTH];
    w_cand_sel   = r_cand[r_bank];
    w_cnt_sel    = r_cnt[r_bank];
    w_state_sel  = state[r_bank*WIDTH +: WIDTH];
    w_cnt_upd    = (w_sample_val == w_cand_sel) ? sat_inc(w_cnt_sel) : CNT_W'(1);
    // after the update the candidate always equals the sample, so that is the accepted value
    w_accept     = (w_cnt_upd == CNT_MAX) && (w_sample_val != w_state_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        r_cand[b] <= '0;
        r_cnt[b]  <= '0;
      end
      state     <= '0;
      changed   <= '0;
      scan_done <= 1'b0;
    end else begin
      changed   <= '0;
      scan_done <= w_pass_end;
      if (w_sample) begin
        r_cand[r_bank] <= w_sample_val;
        r_cnt[r_bank]  <= w_cnt_upd;
        if (w_accept) begin
          state[r_bank*WIDTH +: WIDTH] <= w_sample_val;
          changed[r_bank]              <= 1'b1;
        end
      end
    end
  end

  assign bank_sel = r_bank;

endmodule

// File: tb/tb_pull_down_scan_ctrl.sv
// Bench for pull_down_scan_ctrl: table of per-pass pin values with a queue of expected debounce results,
// plus sequences for idle, mid-pass enable drop, pin drive pattern and asynchronous reset.
module tb_pull_down_scan_ctrl;
  localparam int BANKS = 3;
  localparam int WIDTH = 8;
  localparam int N     = BANKS * WIDTH;
`ifdef PD_SCAN_SYNC_EN
  localparam int SLOT = 9;
`else
  localparam int SLOT = 7;
`endif
  localparam int PASS = SLOT * BANKS;
  localparam int NVEC = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  wire  [N-1:0]     pins;
  logic [N-1:0]     state;
  logic [BANKS-1:0] changed;
  logic             scan_done;
  logic [1:0]       bank_sel;

  logic [BANKS-1:0] ext_en = '0;
  logic [N-1:0]     ext_val = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  pull_down_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pins(pins),
    .state(state), .changed(changed), .scan_done(scan_done), .bank_sel(bank_sel)
  );

  // Board model: each bank's external source can be released; a weak pull-up shows floating bits as 1
  for (genvar b = 0; b < BANKS; b++) begin : g_ext
    assign pins[b*WIDTH +: WIDTH] = ext_en[b] ? ext_val[b*WIDTH +: WIDTH] : {WIDTH{1'bz}};
  end
  for (genvar i = 0; i < N; i++) begin : g_pu
    pullup pu (pins[i]);
  end

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     v;
    logic [BANKS-1:0] acc;
  } vec_t;

  typedef struct {
    logic [N-1:0]     st;
    logic [BANKS-1:0] chg;
    logic             sd;
    logic [1:0]       sel;
    int               at;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    if (cyc > t) begin
      total++;
      bad++;
      $display("FAIL sched @cyc %0d: got past want %0d", cyc, t);
    end
    while (cyc < t) tick();
  endtask

  // Expected pin word k cycles into a pass: only the bank in its 2 discharge cycles reads 0
  function automatic logic [N-1:0] drv_exp(input int k);
    logic [N-1:0] e;
    e = '1;
    if ((k % SLOT) < 2 && (k / SLOT) < BANKS) e[(k / SLOT)*WIDTH +: WIDTH] = '0;
    return e;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_st;
    exp_t         e;
    int           t0, t1, sd_cnt, chg_cnt;

    vecs[0]  = '{v: {8'h00, 8'hA5, 8'h00}, acc: 3'b000};
    vecs[1]  = '{v: {8'h00, 8'hA5, 8'h00}, acc: 3'b000};
    vecs[2]  = '{v: {8'h00, 8'hA5, 8'h00}, acc: 3'b010};
    vecs[3]  = '{v: {8'h00, 8'hA5, 8'h01}, acc: 3'b000};
    vecs[4]  = '{v: {8'h00, 8'hA5, 8'h01}, acc: 3'b000};
    vecs[5]  = '{v: {8'h00, 8'hA5, 8'h00}, acc: 3'b000};
    vecs[6]  = '{v: {8'h00, 8'hA5, 8'h01}, acc: 3'b000};
    vecs[7]  = '{v: {8'h00, 8'hA5, 8'h01}, acc: 3'b000};
    vecs[8]  = '{v: {8'h00, 8'hA5, 8'h01}, acc: 3'b001};
    vecs[9]  = '{v: {8'h3C, 8'h5A, 8'h01}, acc: 3'b000};
    vecs[10] = '{v: {8'h3C, 8'h5A, 8'h01}, acc: 3'b000};
    vecs[11] = '{v: {8'h3C, 8'h5A, 8'h01}, acc: 3'b110};

    // Reset and idle with enable low: no drive, no outputs
    repeat (3) tick();
    check("rst_pins", pins, {N{1'b1}});
    check("rst_state", state, 0);
    check("rst_changed", changed, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_bank_sel", bank_sel, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      check("idle_pins", pins, {N{1'b1}});
      check("idle_bank_sel", bank_sel, 0);
      check("idle_state", state, 0);
      check("idle_changed", changed, 0);
      check("idle_scan_done", scan_done, 0);
    end

    // Table-driven debounce passes
    ext_en  = '1;
    ext_val = vecs[0].v;
    enable  = 1'b1;
    t0      = cyc + 1;
    exp_st  = '0;
    for (int p = 0; p < NVEC; p++) begin
      ext_val = vecs[p].v;
      for (int b = 0; b < BANKS; b++) begin
        if (vecs[p].acc[b]) exp_st[b*WIDTH +: WIDTH] = vecs[p].v[b*WIDTH +: WIDTH];
        e.st  = exp_st;
        e.chg = vecs[p].acc[b] ? BANKS'(1 << b) : '0;
        e.sd  = (b == BANKS - 1);
        e.sel = 2'((b + 1) % BANKS);
        e.at  = t0 + PASS*p + SLOT*(b + 1);
        sb.push_back(e);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_until(e.at);
        check("vec_state", state, e.st);
        check("vec_changed", changed, e.chg);
        check("vec_scan_done", scan_done, e.sd);
        check("vec_bank_sel", bank_sel, e.sel);
        tick();
        check("vec_changed_clr", changed, 0);
        check("vec_scan_done_clr", scan_done, 0);
      end
    end

    // Drop enable in the middle of bank 1: pass still completes, then idle
    wait_until(t0 + NVEC*PASS + SLOT + 3);
    enable  = 1'b0;
    sd_cnt  = 0;
    chg_cnt = 0;
    while (cyc < t0 + (NVEC + 1)*PASS + 3) begin
      tick();
      if (scan_done) sd_cnt++;
      if (changed != 0) chg_cnt++;
      if (cyc == t0 + NVEC*PASS + 2*SLOT + 1) check("drop_bank2", bank_sel, 2);
      if (cyc == t0 + (NVEC + 1)*PASS) check("drop_scan_done", scan_done, 1);
    end
    check("drop_sd_count", sd_cnt, 1);
    check("drop_chg_count", chg_cnt, 0);
    check("drop_state", state, exp_st);
    ext_en = '0;
    for (int k = 0; k < 2*PASS; k++) begin
      tick();
      check("drop_idle_pins", pins, {N{1'b1}});
      check("drop_idle_sel", bank_sel, 0);
    end

    // Drive pattern over one full pass with all external sources released
    enable = 1'b1;
    t1 = cyc + 1;
    for (int k = 0; k < PASS; k++) begin
      wait_until(t1 + k);
      check("drv_pins", pins, drv_exp(k));
      check("drv_sel", bank_sel, k / SLOT);
    end

    // Asynchronous reset while bank 0 discharges
    wait_until(t1 + PASS);
    check("pre_rst_pins", pins, drv_exp(0));
    rst_n = 1'b0;
    #1;
    check("arst_pins", pins, {N{1'b1}});
    check("arst_state", state, 0);
    check("arst_scan_done", scan_done, 0);
    check("arst_sel", bank_sel, 0);
    repeat (3) begin
      tick();
      check("arst_hold_pins", pins, {N{1'b1}});
    end
    rst_n = 1'b1;
    t1 = cyc + 1;
    for (int k = 0; k <= SLOT; k++) begin
      wait_until(t1 + k);
      check("restart_pins", pins, drv_exp(k));
      check("restart_sel", bank_sel, k / SLOT);
      check("restart_state", state, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
